rs_frame_buffer: RTL and testbench
==================================

// Module: rs_frame_buffer
// PURPOSE
//  Collects single-cycle byte strobes (data byte + one-cycle ce pulse) from the UART-side
//  byte-capture FSM into fixed-length Reed-Solomon message frames. Ping-pong buffers
//  them (two banks of MSG_LEN bytes) and streams each complete frame to the RS encoder
//  over a valid/ready interface with start/end-of-frame flags.
// PARAMETERS
//  MSG_LEN         223     message bytes per frame (k of RS(255,223)); legal range 2..255
//  TIMEOUT_CYCLES  100000  idle cycles before a partial frame is flushed (FLUSH_TIMEOUT_EN only)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset      in   1  asynchronous, active-high reset
//  in_byte    in   8  byte from capture FSM; sampled only when in_ce=1
//  in_ce      in   1  one-cycle write strobe for in_byte
//  m_data     out  8  frame byte to RS encoder
//  m_valid    out  1  m_data valid
//  m_ready    in   1  encoder accepts m_data this cycle
//  m_sof      out  1  high with frame byte 0
//  m_eof      out  1  high with frame byte MSG_LEN-1
//  busy       out  1  at least one bank full or sending
//  overflow   out  1  one-cycle pulse: byte dropped, both banks full
// BEHAVIOUR
//  - Reset: m_data=0, m_valid=0, m_sof=0, m_eof=0, busy=0, overflow=0. Both banks
//    empty, fill pointer = bank 0, fill index 0, send index 0. Assertion mid-frame
//    discards all buffered data immediately, with no partial frame emitted.
//  - Fill side: in_ce writes in_byte to fill_bank[fill_idx] and increments fill_idx.
//    The write with fill_idx==MSG_LEN-1 marks the bank FULL (len=MSG_LEN), resets
//    fill_idx to 0 and toggles the fill pointer.
//  - Full check uses registered bank state. If in_ce arrives while the target bank is
//    FULL/SENDING, the byte is dropped and overflow pulses for the next cycle.
//    Applies even if the sender frees that bank on the same edge.
//  - Send FSM states are IDLE, LOAD and STREAM.
//    - IDLE: if send bank FULL -> LOAD.
//    - LOAD: one cycle, synchronous read of byte 0 -> STREAM with m_valid=1, m_sof=1.
//    - STREAM: a transfer is m_valid & m_ready. m_data/m_sof/m_eof stay stable while
//      m_valid & !m_ready. Next byte is presented the cycle after each transfer, with
//      no bubble (prefetch register).
//    - Transfer with m_eof=1: bank -> EMPTY, send pointer toggles. Go to LOAD if the
//      other bank is FULL (one-cycle gap), else IDLE.
//  - Latency: m_valid rises 2 cycles after the edge that samples the completing in_ce
//    (bank FULL at +1, LOAD, data at +2), provided the sender is IDLE.
//  - Frames are emitted strictly in fill order. m_valid never asserted for an empty bank.
//  - Indices are $clog2(MSG_LEN) bits wide and never exceed MSG_LEN-1. No wrap beyond.
//  - busy = any bank FULL or send FSM != IDLE.
// CONFIGURATION
//  FLUSH_TIMEOUT_EN defined:
//   - An idle counter clears on in_ce. While 0 < fill_idx and the counter reaches
//     TIMEOUT_CYCLES, the fill bank is marked FULL with len=fill_idx; fill_idx -> 0 and
//     the fill pointer toggles.
//   - Sender emits stored bytes for index < len and 0x00 for len..MSG_LEN-1. A frame is
//     always MSG_LEN bytes; m_eof stays on byte MSG_LEN-1.
//   - in_ce on the timeout cycle wins: the byte is written and the counter clears.
//  FLUSH_TIMEOUT_EN undefined:
//   - No idle counter and no len storage. A partial frame waits indefinitely.
// TESTING (bench uses MSG_LEN=4, TIMEOUT_CYCLES=16)
//  1 Bytes 11,22,33,44 with m_ready=1 -> m_valid 2 cycles after 4th ce; out 11(sof),22,33,44(eof)
//  2 Same frame, m_ready low 3 cycles on byte 22 -> m_data holds 22, no loss/duplication
//  3 12 bytes back-to-back ce, m_ready=0 -> bytes 9..12 dropped, overflow pulses 4x;
//    then m_ready=1 -> frames 1-4, 5-8 only
//  4 Second frame completes while first streams -> output continuous, 1-cycle gap before sof of frame 2
//  5 Reset asserted mid-stream (byte 2 of 4) -> all outputs 0 same cycle; next frame starts clean at sof
//  6 FLUSH_TIMEOUT_EN: bytes AA,BB then 16 idle cycles -> frame AA,BB,00,00 with eof on 4th byte

Source files
------------

// File: rtl/rs_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// rs_frame_buffer_if
// Byte stream from the frame buffer to the Reed-Solomon encoder.
//   m_data   [7:0]  frame byte
//   m_valid         m_data valid
//   m_ready         encoder accepts m_data this cycle
//   m_sof           high with frame byte 0
//   m_eof           high with the last frame byte
// Modports: master (frame buffer side), slave (encoder side).
// -----------------------------------------------------------------------------
interface rs_frame_buffer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_sof;
    logic       m_eof;

    modport master (
        output m_data,
        output m_valid,
        output m_sof,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_sof,
        input  m_eof,
        output m_ready
    );
endinterface

// File: rtl/rs_frame_buffer.sv
// -----------------------------------------------------------------------------
// rs_frame_buffer
// Collects single-cycle byte strobes into fixed-length Reed-Solomon message
// frames using two ping-pong banks of MSG_LEN bytes, and streams each complete
// frame to the RS encoder over a valid/ready link with sof/eof flags.
//
// Parameters
//   MSG_LEN         message bytes per frame (2..255)
//   TIMEOUT_CYCLES  idle cycles before a partial frame is flushed
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   in_byte   in   byte from the capture FSM, sampled when in_ce=1
//   in_ce     in   one-cycle write strobe
//   m_if      master modport of rs_frame_buffer_if (frame byte stream)
//   busy      out  a bank is full or the sender is not idle
//   overflow  out  one-cycle pulse: a byte was dropped, target bank occupied
//
// Optional feature (macro FLUSH_TIMEOUT_EN): an idle counter flushes a partial
// frame after TIMEOUT_CYCLES cycles without in_ce; the frame is zero-padded to
// MSG_LEN bytes on output. Without the macro a partial frame waits forever.
// -----------------------------------------------------------------------------
module rs_frame_buffer #(
    parameter int MSG_LEN        = 223,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_byte,
    input  logic              in_ce,
    rs_frame_buffer_if.master m_if,
    output logic              busy,
    output logic              overflow
);

    localparam int            IW       = $clog2(MSG_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_mem [2][MSG_LEN];
    logic [1:0]    r_full;          // bank holds a frame (waiting or being sent)
    logic          r_fill_ptr;
    logic          r_send_ptr;
    logic [IW-1:0] r_fill_idx;
    logic [IW-1:0] r_send_idx;      // index of the byte currently on m_data

    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_sof;
    logic          r_eof;
    logic          r_overflow;

    logic          w_fill_ok;
    logic          w_fill_last;
    logic          w_flush;
    logic          w_close;
    logic [1:0]    w_set;
    logic [1:0]    w_clr;
    logic          w_load;
    logic          w_adv;
    logic          w_done;
    logic [IW-1:0] w_rd_idx;
    logic [7:0]    w_rd_byte;

    // The occupancy test uses registered bank state only, so a bank freed by
    // the sender on this same edge still rejects the incoming byte.
    assign w_fill_ok   = in_ce & ~r_full[r_fill_ptr];
    assign w_fill_last = w_fill_ok & (r_fill_idx == LAST_IDX);
    assign w_close     = w_fill_last | w_flush;

    // Set and clear never hit the same bank: fill only closes an empty bank,
    // the sender only releases an occupied one.
    assign w_set = {w_close & r_fill_ptr, w_close & ~r_fill_ptr};
    assign w_clr = {w_done & r_send_ptr, w_done & ~r_send_ptr};

    // Byte 0 when loading a frame, otherwise the byte after the current one.
    assign w_rd_idx = (w_load || (r_send_idx == LAST_IDX)) ? '0 : r_send_idx + 1'b1;

`ifdef FLUSH_TIMEOUT_EN
    localparam int            TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int            LW          = $clog2(MSG_LEN + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_idle;
    logic [LW-1:0] r_len [2];

    // A strobe on the timeout cycle wins: the byte is stored instead.
    assign w_flush = ~in_ce & (r_fill_idx != '0) & (r_idle == TIMEOUT_VAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
            r_len  <= '{default: '0};
        end else begin
            if (in_ce || w_flush)
                r_idle <= '0;
            else if (r_idle != TIMEOUT_VAL)
                r_idle <= r_idle + 1'b1;

            if (w_fill_last)
                r_len[r_fill_ptr] <= LW'(MSG_LEN);
            else if (w_flush)
                r_len[r_fill_ptr] <= LW'(r_fill_idx);
        end
    end

    // Bytes beyond the stored length of a flushed frame read as zero padding.
    always_comb begin
        w_rd_byte = r_mem[r_send_ptr][w_rd_idx];
        if (LW'(w_rd_idx) >= r_len[r_send_ptr])
            w_rd_byte = 8'h00;
    end
`else
    assign w_flush   = 1'b0;
    assign w_rd_byte = r_mem[r_send_ptr][w_rd_idx];
`endif

    // Fill side
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill_ptr <= 1'b0;
            r_fill_idx <= '0;
            r_full     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full     <= (r_full & ~w_clr) | w_set;
            r_overflow <= in_ce & r_full[r_fill_ptr];
            if (w_close) begin
                r_fill_idx <= '0;
                r_fill_ptr <= ~r_fill_ptr;
            end else if (w_fill_ok) begin
                r_fill_idx <= r_fill_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_ok)
            r_mem[r_fill_ptr][r_fill_idx] <= in_byte;
    end

    // Send FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_send_ptr])
                    w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (r_valid && m_if.m_ready) begin
                    if (r_eof) begin
                        w_done      = 1'b1;
                        w_state_nxt = r_full[~r_send_ptr] ? S_LOAD : S_IDLE;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output register doubles as the prefetch stage: the next byte is read
    // on the transfer edge, so back-to-back transfers have no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_send_ptr <= 1'b0;
            r_send_idx <= '0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end else if (w_load) begin
            r_send_idx <= '0;
            r_data     <= w_rd_byte;
            r_valid    <= 1'b1;
            r_sof      <= 1'b1;
            r_eof      <= 1'b0;
        end else if (w_adv) begin
            r_send_idx <= w_rd_idx;
            r_data     <= w_rd_byte;
            r_sof      <= 1'b0;
            r_eof      <= (w_rd_idx == LAST_IDX);
        end else if (w_done) begin
            r_send_ptr <= ~r_send_ptr;
            r_send_idx <= '0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end
    end

    assign m_if.m_data  = r_data;
    assign m_if.m_valid = r_valid;
    assign m_if.m_sof   = r_sof;
    assign m_if.m_eof   = r_eof;
    assign overflow     = r_overflow;
    assign busy         = (|r_full) | (r_state != S_IDLE);

endmodule

// File: tb/tb_rs_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_rs_frame_buffer
// Directed scenarios plus a randomized phase for rs_frame_buffer (MSG_LEN=4,
// TIMEOUT_CYCLES=16). A frame-level reference model (queues of bytes and a
// count of occupied banks) predicts every output transfer, busy and overflow.
// -----------------------------------------------------------------------------
module tb_rs_frame_buffer;

    localparam int MSG_LEN = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_ce = 1'b0;
    logic       busy;
    logic       overflow;

    rs_frame_buffer_if m_if ();

    rs_frame_buffer #(
        .MSG_LEN        (MSG_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_byte  (in_byte),
        .in_ce    (in_ce),
        .m_if     (m_if),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model (updated at negedge) ----------------
    logic [7:0] exp_q[$];    // bytes of completed frames, oldest first
    logic [7:0] part_q[$];   // bytes of the frame being filled
    int         occ = 0;     // frames accepted but not yet fully sent
    int         pos = 0;     // byte position within the frame on the wire
    int         idle_cnt = 0;
    bit         exp_ovf = 1'b0;
    int         ovf_cnt = 0;
    int         xfer_cnt = 0;

    always @(negedge clk) begin
        int eof_x;
        int done;
        if (reset) begin
            exp_q.delete();
            part_q.delete();
            occ      = 0;
            pos      = 0;
            idle_cnt = 0;
            exp_ovf  = 1'b0;
        end else begin
            eof_x = 0;
            done  = 0;
            chk("overflow", overflow, exp_ovf);
            chk("busy", busy, occ != 0);
            if (overflow) ovf_cnt++;
            if (m_if.m_valid) chk("valid_without_frame", exp_q.size() != 0, 1);
            if (m_if.m_valid && m_if.m_ready) begin
                xfer_cnt++;
                if (exp_q.size() != 0) begin
                    chk("data", m_if.m_data, exp_q[0]);
                    chk("sof", m_if.m_sof, pos == 0);
                    chk("eof", m_if.m_eof, pos == MSG_LEN - 1);
                    void'(exp_q.pop_front());
                    pos++;
                    if (pos == MSG_LEN) begin
                        pos   = 0;
                        eof_x = 1;
                    end
                end
            end
            exp_ovf = 1'b0;
            if (in_ce) begin
                idle_cnt = 0;
                if (occ == 2) begin
                    exp_ovf = 1'b1;
                end else begin
                    part_q.push_back(in_byte);
                    if (part_q.size() == MSG_LEN) begin
                        foreach (part_q[i]) exp_q.push_back(part_q[i]);
                        part_q.delete();
                        done = 1;
                    end
                end
            end
`ifdef FLUSH_TIMEOUT_EN
            else if (part_q.size() != 0 && idle_cnt == TIMEOUT) begin
                for (int i = 0; i < MSG_LEN; i++)
                    exp_q.push_back(i < part_q.size() ? part_q[i] : 8'h00);
                part_q.delete();
                idle_cnt = 0;
                done     = 1;
            end else if (idle_cnt < TIMEOUT) begin
                idle_cnt++;
            end
`endif
            occ = occ - eof_x + done;
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b);
        in_byte = b;
        in_ce   = 1'b1;
        cyc(1);
        in_ce   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int n);
        int k = 0;
        while ((busy || m_if.m_valid) && k < n) begin
            cyc(1);
            k++;
        end
        chk(tag, busy | m_if.m_valid, 0);
    endtask

    task automatic wait_byte(input string tag, input logic [7:0] d, input int n);
        bit found = 1'b0;
        for (int k = 0; k < n && !found; k++) begin
            cyc(1);
            if (m_if.m_valid && m_if.m_data == d) found = 1'b1;
        end
        chk(tag, found, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, m_if.m_valid, 0);
        chk({tag, "_data"}, m_if.m_data, 0);
        chk({tag, "_sof"}, m_if.m_sof, 0);
        chk({tag, "_eof"}, m_if.m_eof, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_o;
        int base_x;
        int gap;
        bit seen;

        m_if.m_ready = 1'b0;
        #2;
        chk_reset_outputs("rst");
        cyc(2);
        reset = 1'b0;

        // 1: single frame, ready high, latency of two edges
        m_if.m_ready = 1'b1;
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        chk("t1_lat0", m_if.m_valid, 0);
        cyc(1);
        chk("t1_lat1", m_if.m_valid, 0);
        cyc(1);
        chk("t1_lat2", m_if.m_valid, 1);
        chk("t1_sof", m_if.m_sof, 1);
        chk("t1_d0", m_if.m_data, 8'h11);
        wait_idle("t1_idle", 40);

        // 2: stall three cycles on the second byte
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        wait_byte("t2_find22", 8'h22, 20);
        m_if.m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("t2_hold_valid", m_if.m_valid, 1);
            chk("t2_hold_data", m_if.m_data, 8'h22);
            chk("t2_hold_sof", m_if.m_sof, 0);
        end
        m_if.m_ready = 1'b1;
        wait_idle("t2_idle", 40);

        // 3: twelve back-to-back bytes with the encoder stalled
        base_o = ovf_cnt;
        base_x = xfer_cnt;
        m_if.m_ready = 1'b0;
        for (int k = 1; k <= 12; k++) put(8'(k));
        cyc(3);
        chk("t3_ovf_pulses", ovf_cnt - base_o, 4);
        m_if.m_ready = 1'b1;
        wait_idle("t3_idle", 60);
        chk("t3_xfers", xfer_cnt - base_x, 8);

        // 4: second frame completes while the first streams
        for (int k = 0; k < 8; k++) put(8'h30 + 8'(k));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (m_if.m_valid && m_if.m_eof) seen = 1'b1;
            else cyc(1);
        end
        chk("t4_eof_seen", seen, 1);
        gap = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (m_if.m_valid) break;
            gap++;
        end
        chk("t4_gap", gap, 1);
        chk("t4_sof2", m_if.m_sof, 1);
        chk("t4_d2", m_if.m_data, 8'h34);
        wait_idle("t4_idle", 40);

        // 5: reset while the second byte is on the wire
        put(8'h51); put(8'h52); put(8'h53); put(8'h54);
        wait_byte("t5_find52", 8'h52, 20);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("t5_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        put(8'h61); put(8'h62); put(8'h63); put(8'h64);
        wait_byte("t5_find61", 8'h61, 10);
        chk("t5_sof", m_if.m_sof, 1);
        wait_idle("t5_idle", 40);

`ifdef FLUSH_TIMEOUT_EN
        // 6: partial frame flushed after the idle timeout
        base_x = xfer_cnt;
        put(8'hAA); put(8'hBB);
        for (int k = 0; k < 80 && (xfer_cnt - base_x) < MSG_LEN; k++) cyc(1);
        chk("t6_xfers", xfer_cnt - base_x, MSG_LEN);
        wait_idle("t6_idle", 20);
`endif

        // randomized phase: light then heavy back-pressure
        for (int i = 0; i < 1200; i++) begin
            in_ce   = ($urandom % 3) == 0;
            in_byte = 8'($urandom);
            if (i < 600) m_if.m_ready = ($urandom % 4) != 0;
            else         m_if.m_ready = ($urandom % 4) == 0;
            cyc(1);
        end
        in_ce = 1'b0;
        m_if.m_ready = 1'b1;
        cyc(2 * TIMEOUT + 40);
        chk("drain_frames", exp_q.size(), 0);
        chk("drain_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
